// File: rtl/rot_ififo.sv
// Read-data capture FIFO for the rotate engine: follows the AHB address/data
// pipeline, extracts the active byte/halfword lane of HRDATA and buffers it.
module rot_ififo #(
  parameter int P_DEPTH = 16,
  parameter int P_AW    = 4
) (
  input  logic              I_IFIFO_HCLK,
  input  logic              I_IFIFO_HRESET_N,
  input  logic [31:0]       I_IFIFO_HRDATA,
  input  logic [1:0]        I_IFIFO_HTRANS,
  input  logic              I_IFIFO_HWRITE,
  input  logic [2:0]        I_IFIFO_HSIZE,
  input  logic [1:0]        I_IFIFO_HADDR,
  input  logic              I_IFIFO_HREADY,
  input  logic              I_IFIFO_POP,
  input  logic              I_IFIFO_CLEAR,
  output logic [31:0]       O_IFIFO_DATA,
  output logic              O_IFIFO_EMPTY,
  output logic              O_IFIFO_FULL,
  output logic [P_AW:0]     O_IFIFO_COUNT,
  output logic              O_IFIFO_OVERFLOW
);

  localparam logic [P_AW:0] DEPTH_C = (P_AW+1)'(P_DEPTH);

  logic [31:0]     mem_q [P_DEPTH];
  logic [P_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_AW:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            dp_valid_q, dp_valid_d;
  logic [2:0]      dp_size_q, dp_size_d;
  logic [1:0]      dp_lane_q, dp_lane_d;
  logic            push_req_s, push_s, pop_s, mem_we_s;
  logic [31:0]     wdata_s;

  // Little-endian lane select; unknown size codes pass the full word.
  function automatic logic [31:0] lane_extract(input logic [31:0] data,
                                               input logic [2:0]  size,
                                               input logic [1:0]  lane);
    logic [31:0] res;
    case (size)
      3'b000: begin
        case (lane)
          2'd0:    res = {24'h000000, data[7:0]};
          2'd1:    res = {24'h000000, data[15:8]};
          2'd2:    res = {24'h000000, data[23:16]};
          2'd3:    res = {24'h000000, data[31:24]};
          default: res = 32'h00000000;
        endcase
      end
      3'b001: begin
        if (lane[1]) res = {16'h0000, data[31:16]};
        else         res = {16'h0000, data[15:0]};
      end
      default: res = data;
    endcase
    return res;
  endfunction

  always_comb begin
    push_req_s = dp_valid_q & I_IFIFO_HREADY;
    pop_s      = I_IFIFO_POP & ~empty_q;
    // A full FIFO still accepts a beat when the head leaves on the same edge.
    push_s     = push_req_s & (~full_q | pop_s);
    mem_we_s   = push_s & ~I_IFIFO_CLEAR;
    wdata_s    = lane_extract(I_IFIFO_HRDATA, dp_size_q, dp_lane_q);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    dp_valid_d = dp_valid_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;

    if (I_IFIFO_CLEAR) begin
      wr_ptr_d   = {P_AW{1'b0}};
      rd_ptr_d   = {P_AW{1'b0}};
      count_d    = {(P_AW+1){1'b0}};
      ovf_d      = 1'b0;
      dp_valid_d = 1'b0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + P_AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + P_AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      count_d = count_q + (P_AW+1)'(push_s) - (P_AW+1)'(pop_s);
      if (push_req_s & ~push_s) ovf_d = 1'b1;
      else                      ovf_d = ovf_q;
      if (I_IFIFO_HREADY) begin
        dp_valid_d = I_IFIFO_HTRANS[1] & ~I_IFIFO_HWRITE;
        dp_size_d  = I_IFIFO_HSIZE;
        dp_lane_d  = I_IFIFO_HADDR;
      end else begin
        dp_valid_d = dp_valid_q;
        dp_size_d  = dp_size_q;
        dp_lane_d  = dp_lane_q;
      end
    end

    empty_d = (count_d == {(P_AW+1){1'b0}});
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge I_IFIFO_HCLK or negedge I_IFIFO_HRESET_N) begin
    if (!I_IFIFO_HRESET_N) begin
      wr_ptr_q   <= {P_AW{1'b0}};
      rd_ptr_q   <= {P_AW{1'b0}};
      count_q    <= {(P_AW+1){1'b0}};
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_size_q  <= 3'b000;
      dp_lane_q  <= 2'b00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      dp_valid_q <= dp_valid_d;
      dp_size_q  <= dp_size_d;
      dp_lane_q  <= dp_lane_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge I_IFIFO_HCLK) begin
    if (mem_we_s) mem_q[wr_ptr_q] <= wdata_s;
  end

  always_comb begin
    if (empty_q) O_IFIFO_DATA = 32'h00000000;
    else         O_IFIFO_DATA = mem_q[rd_ptr_q];
  end

  assign O_IFIFO_EMPTY    = empty_q;
  assign O_IFIFO_FULL     = full_q;
  assign O_IFIFO_COUNT    = count_q;
  assign O_IFIFO_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_rot_ififo.sv
// Self-checking bench for rot_ififo: directed scenarios plus random AHB traffic
// compared against a queue-based reference model.
module tb_rot_ififo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hrdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b000;
  logic [1:0]  haddr = 2'b00;
  logic        hready = 1'b1;
  logic        pop = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] dout;
  logic        empty, full, ovf;
  logic [4:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_pv = 1'b0;
  logic [2:0]  m_ps = 3'b000;
  logic [1:0]  m_pl = 2'b00;

  rot_ififo #(.P_DEPTH(16), .P_AW(4)) dut (
    .I_IFIFO_HCLK(clk), .I_IFIFO_HRESET_N(rst_n), .I_IFIFO_HRDATA(hrdata),
    .I_IFIFO_HTRANS(htrans), .I_IFIFO_HWRITE(hwrite), .I_IFIFO_HSIZE(hsize),
    .I_IFIFO_HADDR(haddr), .I_IFIFO_HREADY(hready), .I_IFIFO_POP(pop),
    .I_IFIFO_CLEAR(clr), .O_IFIFO_DATA(dout), .O_IFIFO_EMPTY(empty),
    .O_IFIFO_FULL(full), .O_IFIFO_COUNT(count), .O_IFIFO_OVERFLOW(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lane(input logic [31:0] d, input logic [2:0] sz,
                                           input logic [1:0] ln);
    if (sz == 3'd0) return (d >> (8 * ln)) & 32'h000000FF;
    if (sz == 3'd1) return (d >> (16 * ln[1])) & 32'h0000FFFF;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_pv  = 1'b0;
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    bit do_pop;
    if (clr) begin
      model_reset();
    end else begin
      do_pop = pop && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (m_pv && hready) begin
        if (mq.size() < DEPTH) mq.push_back(ref_lane(hrdata, m_ps, m_pl));
        else m_ovf = 1'b1;
      end
      if (hready) begin
        m_pv = htrans[1] && !hwrite;
        m_ps = hsize;
        m_pl = haddr;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count"}, 32'(count), 32'(mq.size()));
    chk({tag, "/empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "/full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, "/ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, "/data"},  dout, (mq.size() > 0) ? mq[0] : 32'h0);
  endtask

  task automatic cyc(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [1:0] ad, input logic [31:0] rd, input logic rdy,
                     input logic pp, input logic cl, input string tag);
    htrans = tr; hwrite = wr; hsize = sz; haddr = ad;
    hrdata = rd; hready = rdy; pop = pp; clr = cl;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_expect(input logic [31:0] exp, input string tag);
    chk({tag, "/head"}, dout, exp);
    cyc(2'b00, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] words[4];
    logic [1:0]  tr_r;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // word INCR4, no waits
    cyc(2'b10, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "incr4_a0");
    for (int i = 0; i < 4; i++) begin
      cyc((i < 3) ? 2'b11 : 2'b00, 1'b0, 3'd2, 2'd0, words[i], 1'b1, 1'b0, 1'b0, "incr4");
      chk("incr4_cnt", 32'(count), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) pop_expect(words[i], "incr4_pop");
    chk("incr4_empty", 32'(empty), 32'd1);

    // byte lanes
    cyc(2'b10, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "byte_a0");
    for (int i = 1; i < 5; i++)
      cyc((i < 4) ? 2'b10 : 2'b00, 1'b0, 3'd0, 2'(i), 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, "byte");
    pop_expect(32'h000000AA, "byte_pop");
    pop_expect(32'h000000BB, "byte_pop");
    pop_expect(32'h000000CC, "byte_pop");
    pop_expect(32'h000000DD, "byte_pop");

    // halfword lanes with a two-cycle wait state on the second beat
    cyc(2'b10, 1'b0, 3'd1, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "half_a0");
    cyc(2'b10, 1'b0, 3'd1, 2'd2, 32'hBEEFCAFE, 1'b1, 1'b0, 1'b0, "half_d0");
    cyc(2'b00, 1'b0, 3'd1, 2'd0, 32'hBEEFCAFE, 1'b0, 1'b0, 1'b0, "half_wait");
    cyc(2'b00, 1'b0, 3'd1, 2'd0, 32'hBEEFCAFE, 1'b0, 1'b0, 1'b0, "half_wait");
    chk("half_wait_cnt", 32'(count), 32'd1);
    cyc(2'b00, 1'b0, 3'd1, 2'd0, 32'hBEEFCAFE, 1'b1, 1'b0, 1'b0, "half_d1");
    pop_expect(32'h0000CAFE, "half_pop");
    pop_expect(32'h0000BEEF, "half_pop");

    // overflow: 17 word beats, no pops
    for (int i = 0; i < 18; i++)
      cyc((i < 17) ? 2'b10 : 2'b00, 1'b0, 3'd2, 2'd0, 32'hA0000000 + 32'(i), 1'b1, 1'b0, 1'b0, "ovf_fill");
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    cyc(2'b10, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "ovf_a");
    cyc(2'b00, 1'b0, 3'd2, 2'd0, 32'hABCD0000, 1'b1, 1'b1, 1'b0, "ovf_pushpop");
    chk("ovf_pp_cnt", 32'(count), 32'd16);
    chk("ovf_pp_ovf", 32'(ovf), 32'd1);
    cyc(2'b00, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b1, "ovf_clear");
    chk("ovf_clr_cnt", 32'(count), 32'd0);
    chk("ovf_clr_ovf", 32'(ovf), 32'd0);

    // clear on the same edge as a valid data phase and a pop
    cyc(2'b10, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "clr_a0");
    cyc(2'b11, 1'b0, 3'd2, 2'd0, 32'h1, 1'b1, 1'b0, 1'b0, "clr_d0");
    cyc(2'b11, 1'b0, 3'd2, 2'd0, 32'h2, 1'b1, 1'b0, 1'b0, "clr_d1");
    cyc(2'b10, 1'b0, 3'd2, 2'd0, 32'h3, 1'b1, 1'b1, 1'b1, "clr_hit");
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_data", dout, 32'h0);
    cyc(2'b00, 1'b0, 3'd2, 2'd0, 32'h4, 1'b1, 1'b0, 1'b0, "clr_after");
    for (int i = 0; i < 4; i++)
      cyc(2'b10, 1'b1, 3'd2, 2'd0, 32'h55550000 + 32'(i), 1'b1, 1'b0, 1'b0, "write_xfer");
    idle(1, "write_end");
    chk("write_cnt", 32'(count), 32'd0);

    // asynchronous reset mid-burst with five entries held
    cyc(2'b10, 1'b0, 3'd2, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, "arst_a0");
    for (int i = 0; i < 5; i++)
      cyc(2'b11, 1'b0, 3'd2, 2'd0, 32'hC0000000 + 32'(i), 1'b1, 1'b0, 1'b0, "arst_fill");
    chk("arst_pre_cnt", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst_cnt", 32'(count), 32'd0);
    @(negedge clk);
    htrans = 2'b00;
    rst_n = 1'b1;
    idle(2, "arst_post");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tr_r = 2'($urandom_range(0, 3));
      cyc(tr_r, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), $urandom(), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 99) < ((i < 1500) ? 20 : 55)),
          ($urandom_range(0, 99) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
